// File: rtl/reg_scoreboard.sv
// Issue-side scoreboard for the pipelined Y86 register file: per-register pending-write
// counters, RAW/overflow issue hold, and ret/halt control-flow stall sequencing.
module reg_scoreboard #(
    parameter int unsigned NREG   = 15,
    parameter int unsigned CNTW   = 2,
    parameter int unsigned STALLW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dec_valid,
    output logic              dec_ready,
    input  logic [3:0]        dec_icode,
    input  logic [3:0]        dec_srcA,
    input  logic [3:0]        dec_srcB,
    input  logic [3:0]        dec_dstE,
    input  logic [3:0]        dec_dstM,
    input  logic              wb_valid,
    input  logic [3:0]        wb_dstE,
    input  logic [3:0]        wb_dstM,
    input  logic              ret_done,
    output logic [NREG-1:0]   busy_mask,
    output logic              ret_pending,
    output logic              halted,
    output logic [STALLW-1:0] stall_cnt,
    output logic              sb_err
);
    localparam logic [3:0]      RegNone   = 4'hF;
    localparam logic [3:0]      IcodeHalt = 4'h0;
    localparam logic [3:0]      IcodeRet  = 4'h9;
    localparam logic [CNTW-1:0] CntMax    = '1;

    typedef enum logic [1:0] {StRun, StRetWait, StHalt} state_e;

    state_e            state_q, state_d;
    logic [CNTW-1:0]   count_q [NREG];
    logic [CNTW-1:0]   count_d [NREG];
    logic [STALLW-1:0] stall_q, stall_d;
    logic              err_q, err_d;
    logic [NREG-1:0]   inc_v, dec_v;
    logic              issue;

    // Indices >= NREG never match a tracked register, so they behave like "no register".
    function automatic logic hit(input logic [3:0] idx, input int unsigned r);
        return (idx != RegNone) && (idx == 4'(r));
    endfunction

    // Hold decision uses registered counts only; no write-back bypass.
    always_comb begin
        dec_ready = !rst && (state_q == StRun);
        for (int unsigned r = 0; r < NREG; r++) begin
            if ((hit(dec_srcA, r) || hit(dec_srcB, r)) && count_q[r] != '0) dec_ready = 1'b0;
            if ((hit(dec_dstE, r) || hit(dec_dstM, r)) && count_q[r] == CntMax) dec_ready = 1'b0;
        end
    end

    assign issue = dec_valid & dec_ready;

    // dstE == dstM collapses to a single bit, giving the +1/-1 only behaviour.
    always_comb begin
        inc_v = '0;
        dec_v = '0;
        for (int unsigned r = 0; r < NREG; r++) begin
            inc_v[r] = issue && (hit(dec_dstE, r) || hit(dec_dstM, r));
            dec_v[r] = wb_valid && (hit(wb_dstE, r) || hit(wb_dstM, r));
        end
    end

    always_comb begin
        err_d = err_q;
        for (int unsigned r = 0; r < NREG; r++) begin
            count_d[r] = count_q[r];
            if (dec_v[r] && count_q[r] == '0) begin
                err_d = 1'b1;
                if (inc_v[r]) count_d[r] = CNTW'(1);
            end else if (inc_v[r] && !dec_v[r]) begin
                count_d[r] = count_q[r] + CNTW'(1);
            end else if (dec_v[r] && !inc_v[r]) begin
                count_d[r] = count_q[r] - CNTW'(1);
            end
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (dec_valid && !dec_ready && stall_q != '1) stall_d = stall_q + STALLW'(1);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (issue && dec_icode == IcodeRet)       state_d = StRetWait;
                else if (issue && dec_icode == IcodeHalt) state_d = StHalt;
            end
            StRetWait: if (ret_done) state_d = StRun;
            StHalt:    state_d = StHalt;
            default:   state_d = StRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            stall_q <= '0;
            err_q   <= 1'b0;
            for (int unsigned r = 0; r < NREG; r++) count_q[r] <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            err_q   <= err_d;
            for (int unsigned r = 0; r < NREG; r++) count_q[r] <= count_d[r];
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int unsigned r = 0; r < NREG; r++) busy_mask[r] = (count_q[r] != '0);
    end

    assign ret_pending = (state_q == StRetWait);
    assign halted      = (state_q == StHalt);
    assign stall_cnt   = stall_q;
    assign sb_err      = err_q;
endmodule
